mem_arbiter: RTL
================

# mem_arbiter

Two-master arbiter placed directly upstream of the single-port `memory` block. It merges the instruction-fetch port (read-only) and the data load/store port onto one memory port. It owns the memory's one-cycle synchronous read latency and returns read data or write completion to the master that issued the request. Only one transaction is in flight at a time.

## Interface
Parameters
- `ADDR_W`, default 32: address width passed through to memory.

Ports
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `i_req_i`  in  1: fetch request; held with `i_addr_i` stable until `i_gnt_o`.
- `i_addr_i`  in  ADDR_W: fetch byte address.
- `i_gnt_o`  out  1: one-cycle pulse; fetch request latched.
- `i_rvalid_o`  out  1: one-cycle pulse; `i_rdata_o` valid.
- `i_rdata_o`  out  32: fetch data; holds until the next fetch completes.
- `d_req_i`  in  1: data request; held with its payload stable until `d_gnt_o`.
- `d_addr_i`  in  ADDR_W: data byte address.
- `d_wmask_i`  in  4: byte write mask; 0 means a read.
- `d_wdata_i`  in  32: write data, already lane-aligned.
- `d_gnt_o`  out  1: one-cycle pulse; data request latched.
- `d_done_o`  out  1: one-cycle pulse; read data valid, or write committed.
- `d_rdata_o`  out  32: load data; holds until the next data read completes.
- `mem_addr_o`  out  ADDR_W: to memory `mem_addr_i`.
- `mem_rstrb_o`  out  1: to memory `mem_rstrb_i`.
- `mem_wmask_o`  out  4: to memory `mem_wmask_i`.
- `mem_wdata_o`  out  32: to memory `mem_wdata_i`.
- `mem_rdata_i`  in  32: from memory `mem_rdata_o`; valid the cycle after `mem_rstrb_o`.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:** if any request is present:
  - pick a winner;
  - latch addr, wmask and wdata (fetch latches wmask=0) and the owner id;
  - pulse the winner's gnt;
  - go to ISSUE.
  - If no request, stay in IDLE.
- **ISSUE:**
  - drive `mem_addr_o` from the latch;
  - `mem_wmask_o` = latched wmask;
  - `mem_rstrb_o` = (latched wmask == 0);
  - go to WAIT.
- **WAIT:**
  - reads: register `mem_rdata_i` into the owner's rdata register;
  - writes: leave both rdata registers unchanged;
  - set the owner's done/rvalid flop for the next cycle;
  - go to IDLE.
- `mem_rstrb_o` and `mem_wmask_o` are 0 outside ISSUE. `mem_addr_o` and `mem_wdata_o` hold the last latched values.
- A fetch never writes: `i` transactions always have wmask 0.
- Addresses pass through unmodified; memory ignores bits [1:0].
- Both requests in IDLE: arbitration policy is set under Configuration. The loser keeps its req high and is considered again in the next IDLE.
- A request raised outside IDLE is not granted until IDLE.
- A master may hold req high across its own completion. It is regranted in the IDLE cycle in which its done pulses.

## Timing
- Reset values:
  - state = IDLE;
  - all gnt, rvalid and done outputs = 0;
  - `i_rdata_o` = `d_rdata_o` = 0;
  - all `mem_*_o` = 0;
  - last-owner = data.
- Latency: gnt in cycle N (IDLE), ISSUE in N+1, WAIT in N+2, done/rvalid and rdata in N+3.
- Throughput: one transaction per 3 cycles. The cycle N+3 is IDLE and can grant again.
- Reset mid-transaction (ISSUE or WAIT): the transaction is dropped, no done pulse, return to IDLE.
  - Reset asserted in the ISSUE cycle still presents that cycle's write to memory.
- gnt is never asserted to both masters in the same cycle.
- done and rvalid are never asserted together.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on contention, grant the master that was not the last owner. Last owner updates at every grant.
  - After reset the last owner is data, so the first contention goes to fetch.
- Not defined: fixed priority, data port always wins. The last-owner register is not implemented.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE/ISSUE/WAIT);
  - owner id constants `OWN_I` = 0 and `OWN_D` = 1;
  - `WMASK_READ` = 4'b0000.
- One sub-module: `mem_arb_pick`. It is the combinational winner selection from the two reqs and last-owner, and contains the macro-dependent logic.
- The FSM, latches and rdata registers stay in `mem_arbiter`.

## Test plan
- Reset, then fetch only: preload memory word 0x10 = 0xDEADBEEF; hold `i_req_i` with addr 0x40.
  - Required: `i_gnt_o` at N, `mem_rstrb_o`=1 with addr 0x40 at N+1, `i_rvalid_o` at N+3 with `i_rdata_o`=0xDEADBEEF.
- Data write 0xA5A5A5A5 with mask 4'b0011 to addr 0x8, then a data read of 0x8.
  - Required: `mem_wmask_o`=0011 for exactly one cycle, `d_done_o` at N+3, read returns 0x0000A5A5.
- Both reqs held continuously:
  - with macro: grants alternate i, d, i, d, every 3 cycles;
  - without macro: d granted every time and `i_gnt_o` stays 0.
- Back-to-back data reads held high:
  - second `d_gnt_o` in the same cycle as the first `d_done_o`;
  - `i_rdata_o` unchanged throughout.
- `rst` asserted in the WAIT cycle of a fetch:
  - no `i_rvalid_o`;
  - all outputs 0 the next cycle;
  - a new request is granted immediately after reset deasserts.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Pure declarations; no latency of its own.
// No flow control here; consumers apply the ready/valid handshakes.
package mem_arb_pkg;

    // Arbiter FSM: one transaction walks IDLE -> ISSUE -> WAIT -> IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Owner ids for the in-flight transaction and the last-owner register.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // An all-zero byte mask marks a read.
    localparam logic [3:0] WMASK_READ = 4'b0000;

    function automatic logic is_read(input logic [3:0] wmask);
        return wmask == WMASK_READ;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requests.
// Zero latency: pick_i/pick_d follow the requests in the same cycle.
// No backpressure; the caller decides when a pick becomes a grant.
//
// Ports: i_req/d_req = raw requests; last_own = previous grant owner
// (present only with MEM_ARB_ROUND_ROBIN_EN); pick_i/pick_d = one-hot
// winner, both low when nobody requests.
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin on
// contention; otherwise the data port always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_own,
`endif
    output logic pick_i,
    output logic pick_d
);

    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // Contention goes to whoever did not own the previous grant.
            if (last_own == OWN_D) begin
                pick_i = 1'b1;
            end else begin
                pick_d = 1'b1;
            end
`else
            pick_d = 1'b1;
`endif
        end else begin
            pick_i = i_req;
            pick_d = d_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the fetch (read-only) and data ports onto one single-port memory.
// Latency: gnt in IDLE cycle N, memory strobe N+1, done/rvalid + rdata N+3.
// Backpressure: one transaction in flight; requests wait (held) until IDLE.
//
// Ports: clk/rst (sync, active-high); fetch port i_req_i/i_addr_i ->
// i_gnt_o/i_rvalid_o/i_rdata_o; data port d_req_i/d_addr_i/d_wmask_i/
// d_wdata_i -> d_gnt_o/d_done_o/d_rdata_o; memory side mem_addr_o,
// mem_rstrb_o, mem_wmask_o, mem_wdata_o, mem_rdata_i (one-cycle read).
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [31:0]       i_rdata_o,

    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [3:0]        d_wmask_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_done_o,
    output logic [31:0]       d_rdata_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rstrb_o,
    output logic [3:0]        mem_wmask_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);
    import mem_arb_pkg::*;

    state_t            state;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wmask_q;
    logic [31:0]       wdata_q;
    logic              mem_rstrb_q;
    logic [3:0]        mem_wmask_q;
    logic              i_rvalid_q;
    logic              d_done_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;

    logic              pick_i;
    logic              pick_d;
    logic              grant_en;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_own;
`endif

    mem_arb_pick u_pick (
        .i_req    (i_req_i),
        .d_req    (d_req_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_own (last_own),
`endif
        .pick_i   (pick_i),
        .pick_d   (pick_d)
    );

    // Grants are decided in the IDLE cycle itself so a held request is
    // regranted in the same cycle its previous done pulses. Masking with
    // rst keeps the outputs quiet while reset is held.
    assign grant_en = (state == IDLE) && !rst;
    assign i_gnt_o  = grant_en && pick_i;
    assign d_gnt_o  = grant_en && pick_d;

    assign i_rvalid_o  = i_rvalid_q;
    assign d_done_o    = d_done_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_rstrb_o = mem_rstrb_q;
    assign mem_wmask_o = mem_wmask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_q     <= OWN_D;
            addr_q      <= '0;
            wmask_q     <= WMASK_READ;
            wdata_q     <= '0;
            mem_rstrb_q <= 1'b0;
            mem_wmask_q <= WMASK_READ;
            i_rvalid_q  <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_own    <= OWN_D;
`endif
        end else begin
            // Completion flags are single-cycle pulses.
            i_rvalid_q <= 1'b0;
            d_done_q   <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state       <= ISSUE;
                        owner_q     <= OWN_D;
                        addr_q      <= d_addr_i;
                        wmask_q     <= d_wmask_i;
                        wdata_q     <= d_wdata_i;
                        // Memory strobes are registered so they are
                        // asserted for exactly the ISSUE cycle.
                        mem_rstrb_q <= is_read(d_wmask_i);
                        mem_wmask_q <= d_wmask_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_own    <= OWN_D;
`endif
                    end else if (pick_i) begin
                        state       <= ISSUE;
                        owner_q     <= OWN_I;
                        addr_q      <= i_addr_i;
                        // Fetches can never write.
                        wmask_q     <= WMASK_READ;
                        wdata_q     <= '0;
                        mem_rstrb_q <= 1'b1;
                        mem_wmask_q <= WMASK_READ;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_own    <= OWN_I;
`endif
                    end
                end

                ISSUE: begin
                    state       <= WAIT;
                    mem_rstrb_q <= 1'b0;
                    mem_wmask_q <= WMASK_READ;
                end

                WAIT: begin
                    state <= IDLE;
                    // Memory read data is valid now, one cycle after the
                    // strobe; writes leave both data registers untouched.
                    if (owner_q == OWN_I) begin
                        i_rvalid_q <= 1'b1;
                        if (is_read(wmask_q)) begin
                            i_rdata_q <= mem_rdata_i;
                        end
                    end else begin
                        d_done_q <= 1'b1;
                        if (is_read(wmask_q)) begin
                            d_rdata_q <= mem_rdata_i;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    mem_rstrb_q <= 1'b0;
                    mem_wmask_q <= WMASK_READ;
                end
            endcase
        end
    end

endmodule
